// File: rtl/shading_sequencer.sv
// Shading engine: dot product, ambient and diffuse terms on one shared
// 32x32 signed multiplier, producing a packed 24-bit RGB pixel.
module shading_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int OUT_WIDTH  = 24,
  parameter logic [14:0] AMB_R  = 15'd6553,
  parameter logic [14:0] AMB_G  = 15'd9830,
  parameter logic [14:0] AMB_B  = 15'd13107,
  parameter logic [14:0] DIFF_R = 15'd26214,
  parameter logic [14:0] DIFF_G = 15'd22937,
  parameter logic [14:0] DIFF_B = 15'd16384,
  parameter logic [OUT_WIDTH-1:0] BG_COLOR = 24'h000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_hit,
  input  logic [DATA_WIDTH-1:0] nx,
  input  logic [DATA_WIDTH-1:0] ny,
  input  logic [DATA_WIDTH-1:0] nz,
  input  logic [DATA_WIDTH-1:0] lx,
  input  logic [DATA_WIDTH-1:0] ly,
  input  logic [DATA_WIDTH-1:0] lz,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_WIDTH-1:0]  shade_out,
  output logic                  busy
);

  typedef enum logic [3:0] {
    IDLE, DX, DY, DZ, CLIP,
    AR, DR, AG, DG, AB, DB, OUT
  } state_t;

  state_t state, next;

  logic signed [31:0] nx_q, ny_q, nz_q;
  logic signed [31:0] lx_q, ly_q, lz_q;
  logic signed [63:0] acc;
  logic signed [63:0] chan;
  logic signed [31:0] diffuse;
  logic signed [31:0] ambient;
  logic [7:0] r, g, b;

  logic signed [31:0] ma, mb;
  logic signed [63:0] prod;
  logic signed [63:0] sum;
  logic signed [63:0] sh;
  logic signed [31:0] amb_comp;
  logic [7:0] clamp8;

  // The only multiplier in the block
  assign prod = ma * mb;

  assign sum = chan + prod;
  assign sh  = sum >>> 15;
  assign amb_comp = (ny_q > 0) ? ny_q : 32'sd0;

  always_comb begin
    clamp8 = sh[23:16];
    if (sh < 0)
      clamp8 = 8'd0;
    else if (sh >= 64'sh0000_0000_0100_0000)
      clamp8 = 8'd255;
  end

  always_comb begin
    ma = '0;
    mb = '0;
    unique case (state)
      DX: begin ma = nx_q; mb = lx_q; end
      DY: begin ma = ny_q; mb = ly_q; end
      DZ: begin ma = nz_q; mb = lz_q; end
      AR: begin ma = ambient; mb = {17'd0, AMB_R}; end
      DR: begin ma = diffuse; mb = {17'd0, DIFF_R}; end
      AG: begin ma = ambient; mb = {17'd0, AMB_G}; end
      DG: begin ma = diffuse; mb = {17'd0, DIFF_G}; end
      AB: begin ma = ambient; mb = {17'd0, AMB_B}; end
      DB: begin ma = diffuse; mb = {17'd0, DIFF_B}; end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= next;
  end

  always_comb begin
    next      = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid)
          next = in_hit ? DX : OUT;
      end
      DX:   next = DY;
      DY:   next = DZ;
      DZ:   next = CLIP;
      CLIP: next = AR;
      AR:   next = DR;
      DR:   next = AG;
      AG:   next = DG;
      DG:   next = AB;
      AB:   next = DB;
      DB:   next = OUT;
      OUT: begin
        out_valid = 1'b1;
        if (out_ready)
          next = IDLE;
      end
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      nx_q    <= '0;
      ny_q    <= '0;
      nz_q    <= '0;
      lx_q    <= '0;
      ly_q    <= '0;
      lz_q    <= '0;
      acc     <= '0;
      chan    <= '0;
      diffuse <= '0;
      ambient <= '0;
      r       <= '0;
      g       <= '0;
      b       <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            nx_q <= nx;
            ny_q <= ny;
            nz_q <= nz;
            lx_q <= lx;
            ly_q <= ly;
            lz_q <= lz;
            if (!in_hit)
              {r, g, b} <= BG_COLOR;
          end
        end
        DX: acc <= prod;
        DY: acc <= acc + prod;
        DZ: acc <= acc + prod;
        CLIP: begin
          diffuse <= acc[63] ? 32'sd0 : 32'(acc >>> 24);
          ambient <= 32'sh0080_0000 + (amb_comp >>> 1);
        end
        AR: chan <= prod;
        AG: chan <= prod;
        AB: chan <= prod;
        DR: r <= clamp8;
        DG: g <= clamp8;
        DB: b <= clamp8;
        default: ;
      endcase
    end
  end

  assign shade_out = {r, g, b};

endmodule

// File: doc/shading_sequencer.md
Name: shading_sequencer

Overview:
Multi-cycle shading engine for the ray marcher. It accepts one hit record per transaction: a surface normal and a light vector, both Q8.24. It time-multiplexes a single shared 32x32 signed multiplier through the dot-product, ambient and diffuse steps, and returns a packed 24-bit RGB pixel. It sits between the march/normal-estimation stage and the pixel writer, with valid/ready handshakes on both sides.

Parameters:
DATA_WIDTH, 32, width of Q8.24 vector components
OUT_WIDTH, 24, packed RGB width (8 bits per channel, R in [23:16])
AMB_R / AMB_G / AMB_B, 6553 / 9830 / 13107, ambient coefficients, Q0.15, unsigned
DIFF_R / DIFF_G / DIFF_B, 26214 / 22937 / 16384, diffuse coefficients, Q0.15, unsigned
BG_COLOR, 24'h000000, pixel emitted for a miss

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
in_valid  in  1  hit record valid
in_ready  out  1  block can accept a record
in_hit  in  1  1 = ray hit surface, 0 = miss
nx, ny, nz  in  DATA_WIDTH each  normal, signed Q8.24
lx, ly, lz  in  DATA_WIDTH each  light direction, signed Q8.24
out_valid  out  1  shade_out valid
out_ready  in  1  downstream accepts pixel
shade_out  out  OUT_WIDTH  {r,g,b}
busy  out  1  high in every state except IDLE

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values: in_ready=1, out_valid=0, shade_out=0, busy=0, state=IDLE. All accumulators and captured operands are cleared to 0.
- A reset mid-operation abandons the record. No output is produced for it.
- Only one multiplier instance is allowed: 32x32 signed to 64 bits. Q0.15 coefficients are zero-extended to 32 bits.
- FSM states: IDLE, DX, DY, DZ, CLIP, AR, DR, AG, DG, AB, DB, OUT.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, capture all six vectors and in_hit.
  - Next state is DX if in_hit=1, else OUT with shade_out=BG_COLOR.
- DX/DY/DZ:
  - acc64 accumulates nx*lx, then +ny*ly, then +nz*lz (full 64-bit products, no intermediate shift).
- CLIP (no multiply):
  - diffuse = (acc64 < 0) ? 0 : acc64 >>> 24, truncated to 32 bits.
  - amb_comp = (ny > 0) ? ny : 0.
  - ambient = 32'h00800000 (0.5) + (amb_comp >>> 1).
- Channel states:
  - AR: chan = ambient*AMB_R.
  - DR: chan += diffuse*DIFF_R, then register r = clamp(chan >>> 15).
  - AG/DG and AB/DB do the same for the G and B channels.
- clamp(v), applied to the full-width shifted value:
  - v < 0 gives 0.
  - v >= 32'h01000000 gives 255.
  - otherwise v[23:16].
- OUT:
  - out_valid=1, shade_out={r,g,b}, in_ready=0.
  - shade_out and out_valid are held stable until out_ready.
  - On out_valid&&out_ready, the next state is IDLE.
- Latency (handshake edge = cycle 0):
  - Hit: out_valid first high in cycle 11.
  - Miss: out_valid first high in cycle 1.
- No overlap between records. in_ready is 0 in every non-IDLE state. Minimum hit throughput is 1 record per 12 cycles.
- in_valid/vector changes while the block is not in IDLE are ignored.
- Simultaneous out_ready and new in_valid in OUT: the pixel completes, and the new record is accepted no earlier than the following IDLE cycle.

Test Plan:
- Reset: hold rst for 3 cycles with in_valid=1 → in_ready=1, out_valid=0, shade_out=0, busy=0.
- Hit, aligned vectors: n=(0,1.0,0), l=(0,1.0,0) (ny=ly=32'h01000000), out_ready=1 → out_valid exactly in cycle 11, shade_out=24'hFFFFE6, back to IDLE next cycle.
- Hit, back-facing: n=(0,1.0,0), l=(0,-1.0,0) → diffuse clipped to 0, shade_out=24'h334C66.
- Hit, side-lit: n=(1.0,0,0), l=(1.0,0,0) → ambient=0.5, shade_out=24'hE6D9B3. Overflow case: n=l=(2.0,0,0) → shade_out=24'hFFFFFF.
- Miss and backpressure:
  - in_hit=0 → out_valid in cycle 1, shade_out=BG_COLOR.
  - Hold out_ready=0 for 5 cycles → out_valid and shade_out stable, in_ready=0, extra in_valid pulses ignored.
- Reset mid-operation: assert rst in state AG → next cycle IDLE, out_valid=0, shade_out=0. The next record (the side-lit case) yields 24'hE6D9B3 with no residue in the accumulators.
